// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state encoding and the per-channel request bundle for mem_arbiter_n.
// Round-robin arbitration is selected with MEM_ARBITER_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

    localparam int MEM_NUM_CHANNELS = 3;
    localparam int MEM_ADDR_WIDTH   = 19;
    localparam int MEM_DATA_WIDTH   = 16;
    localparam int MEM_BSEL_WIDTH   = MEM_DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH:1]   addr;
        logic [MEM_DATA_WIDTH-1:0] data;
        logic                      wr_en;
        logic [MEM_BSEL_WIDTH-1:0] bytesel;
        logic                      access;
        logic                      lock;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational request picker: fixed priority (lowest index wins) or round-robin
// starting one past ptr. Shared by the memory and IO arbiters.
module mem_arbiter_pick #(
    parameter int NUM_REQ     = 3,
    parameter bit ROUND_ROBIN = 1'b0,
    localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 valid,
    output logic [IDX_WIDTH-1:0] idx
);

    if (ROUND_ROBIN) begin : g_rr
        int cand;
        always_comb begin
            valid = 1'b0;
            idx   = '0;
            cand  = 0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = (int'(ptr) + k) % NUM_REQ;
                if (!valid && req[cand]) begin
                    valid = 1'b1;
                    idx   = IDX_WIDTH'(cand);
                end
            end
        end
    end else begin : g_fixed
        logic unused_ptr;
        assign unused_ptr = ^ptr;
        // Scan downward so the lowest requesting index is the last writer.
        always_comb begin
            valid = 1'b0;
            idx   = '0;
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req[k]) begin
                    valid = 1'b1;
                    idx   = IDX_WIDTH'(k);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel memory bus arbiter with locked multi-transfer ownership onto one downstream port.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin fairness; default is fixed priority.
module mem_arbiter_n
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CHANNELS = MEM_NUM_CHANNELS,
    parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
    localparam int BSEL_WIDTH  = DATA_WIDTH / 8,
    localparam int IDX_WIDTH   = $clog2(NUM_CHANNELS)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH:1]   ch_m_addr,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_m_data_out,
    output logic [DATA_WIDTH-1:0]                   ch_m_data_in,
    input  logic [NUM_CHANNELS-1:0]                 ch_m_access,
    input  logic [NUM_CHANNELS-1:0]                 ch_m_wr_en,
    input  logic [NUM_CHANNELS-1:0][BSEL_WIDTH-1:0] ch_m_bytesel,
    input  logic [NUM_CHANNELS-1:0]                 ch_m_lock,
    output logic [NUM_CHANNELS-1:0]                 ch_m_ack,
    output logic [ADDR_WIDTH:1]                     q_m_addr,
    input  logic [DATA_WIDTH-1:0]                   q_m_data_in,
    output logic [DATA_WIDTH-1:0]                   q_m_data_out,
    output logic                                    q_m_access,
    input  logic                                    q_m_ack,
    output logic                                    q_m_wr_en,
    output logic [BSEL_WIDTH-1:0]                   q_m_bytesel,
    output logic [IDX_WIDTH-1:0]                    grant_owner
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    arb_state_t           state, state_next;
    logic [IDX_WIDTH-1:0] owner, owner_next;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [IDX_WIDTH-1:0] sel;
    logic                 win_valid;
    logic                 grant_active;
    logic                 drive;
    mem_req_t             sel_req;

    mem_arbiter_pick #(
        .NUM_REQ     (NUM_CHANNELS),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .req   (ch_m_access),
        .ptr   (rr_ptr),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            owner <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // A same-cycle ack on an idle request completes without taking ownership unless locked.
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            ST_IDLE: begin
                if (win_valid && (!q_m_ack || ch_m_lock[win_idx])) begin
                    state_next = ST_GRANTED;
                    owner_next = win_idx;
                end
            end
            ST_GRANTED: begin
                if (!ch_m_lock[owner] && (q_m_ack || !ch_m_access[owner])) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_active && !ch_m_lock[owner] && (q_m_ack || !ch_m_access[owner])) begin
            rr_ptr <= owner;
        end else if (!grant_active && win_valid && q_m_ack && !ch_m_lock[win_idx]) begin
            rr_ptr <= win_idx;
        end
    end
`else
    assign rr_ptr = '0;
`endif

    assign grant_active = (state == ST_GRANTED);
    assign sel          = grant_active ? owner : win_idx;
    assign drive        = grant_active || win_valid;
    assign grant_owner  = sel;
    assign ch_m_data_in = q_m_data_in;

    always_comb begin
        sel_req.addr    = ch_m_addr[sel];
        sel_req.data    = ch_m_data_out[sel];
        sel_req.wr_en   = ch_m_wr_en[sel];
        sel_req.bytesel = ch_m_bytesel[sel];
        sel_req.access  = ch_m_access[sel];
        sel_req.lock    = ch_m_lock[sel];
    end

    // A locked owner with access low keeps the bus but presents no request.
    assign q_m_access   = drive && sel_req.access;
    assign q_m_wr_en    = drive && sel_req.wr_en;
    assign q_m_addr     = drive ? sel_req.addr : '0;
    assign q_m_data_out = drive ? sel_req.data : '0;
    assign q_m_bytesel  = drive ? sel_req.bytesel : '1;

    logic unused_sel_lock;
    assign unused_sel_lock = sel_req.lock;

    always_comb begin
        ch_m_ack = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_m_ack[i] = q_m_ack && (IDX_WIDTH'(i) == sel) && (grant_active || ch_m_access[i]);
        end
    end

endmodule
